// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte producers. Every producer
// owns a one-deep holding register. A round-robin scheduler launches one full
// register at a time into the transmitter with a single-cycle data-valid
// pulse. It then waits for the transmitter's done pulse, and after that for
// GAP_CYCLES idle clocks, before it serves anyone else. Only one byte is ever
// outstanding at the transmitter.
//
// Ports
//   i_Clock      system clock, everything on the rising edge
//   i_Reset      synchronous active-high reset, overrides everything
//   i_Req_DV     per-requester byte valid, taken when o_Req_Ready bit is high
//   i_Req_Byte   requester k byte on bits [k*DATA_W +: DATA_W]
//   o_Req_Ready  holding register k is empty
//   o_Tx_DV      one-cycle launch pulse to the transmitter
//   o_Tx_Byte    launched byte, held until the next launch
//   i_Tx_Done    transmitter done pulse; ignored unless waiting for it
//   o_Grant_Id   requester being served / last served
//   o_Busy       high from launch until the end of the post-done gap
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic [NUM_REQ-1:0]         i_Req_DV,
  input  logic [NUM_REQ*DATA_W-1:0]  i_Req_Byte,
  output logic [NUM_REQ-1:0]         o_Req_Ready,
  output logic                       o_Tx_DV,
  output logic [DATA_W-1:0]          o_Tx_Byte,
  input  logic                       i_Tx_Done,
  output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
  output logic                       o_Busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_GAP       = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                hold_full_reg [NUM_REQ];
  logic [DATA_W-1:0]   hold_byte_reg [NUM_REQ];
  logic [NUM_REQ-1:0]  hold_full;
  logic [ID_W-1:0]     ptr_reg, ptr_next;
  logic [ID_W-1:0]     grant_reg, grant_next;
  logic [ID_W-1:0]     pick, cand;
  logic [7:0]          gap_reg, gap_next;
  logic                busy_reg, busy_next;
  logic                tx_dv_reg, tx_dv_next;
  logic [DATA_W-1:0]   tx_byte_reg, tx_byte_next;
  logic                any_full;
  logic                launch;

  // --------------------------------------------------------------------------
  // Holding registers. A launch empties the register it reads. The producer
  // cannot refill that register on the same edge, because its ready bit was
  // low while the register was full.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold
    always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
        hold_full_reg[gi] <= 1'b0;
        hold_byte_reg[gi] <= '0;
      end else if (launch && (pick == ID_W'(gi))) begin
        hold_full_reg[gi] <= 1'b0;
      end else if (i_Req_DV[gi] && !hold_full_reg[gi]) begin
        hold_full_reg[gi] <= 1'b1;
        hold_byte_reg[gi] <= i_Req_Byte[gi*DATA_W +: DATA_W];
      end
    end

    assign hold_full[gi]   = hold_full_reg[gi];
    assign o_Req_Ready[gi] = ~hold_full_reg[gi];
  end

  assign any_full = |hold_full;

  // --------------------------------------------------------------------------
  // Round-robin pick: the first full register found searching upward from
  // ptr+1, wrapping at NUM_REQ. The loop runs from the farthest candidate to
  // the nearest, so the nearest full candidate is the last assignment and
  // therefore wins.
  // --------------------------------------------------------------------------
  always_comb begin
    pick = '0;
    cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(ptr_reg) + i) % NUM_REQ);
      if (hold_full[cand]) begin
        pick = cand;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scheduler FSM: next state and next outputs.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    gap_next     = gap_reg;
    busy_next    = busy_reg;
    tx_dv_next   = 1'b0;
    tx_byte_next = tx_byte_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    launch       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (any_full) begin
          launch       = 1'b1;
          tx_dv_next   = 1'b1;
          tx_byte_next = hold_byte_reg[pick];
          grant_next   = pick;
          ptr_next     = pick;
          busy_next    = 1'b1;
          state_next   = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (i_Tx_Done) begin
          if (GAP_CYCLES == 0) begin
            busy_next  = 1'b0;
            state_next = ST_IDLE;
          end else begin
            gap_next   = 8'(GAP_CYCLES);
            state_next = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        // The count value 1 marks the last idle clock of the gap.
        if (gap_reg <= 8'd1) begin
          gap_next   = 8'd0;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg - 8'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers. The reset value of ptr_reg is NUM_REQ-1, so
  // requester 0 wins the first arbitration after reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_reg   <= ST_IDLE;
      gap_reg     <= 8'd0;
      busy_reg    <= 1'b0;
      tx_dv_reg   <= 1'b0;
      tx_byte_reg <= '0;
      grant_reg   <= '0;
      ptr_reg     <= ID_W'(NUM_REQ - 1);
    end else begin
      state_reg   <= state_next;
      gap_reg     <= gap_next;
      busy_reg    <= busy_next;
      tx_dv_reg   <= tx_dv_next;
      tx_byte_reg <= tx_byte_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
    end
  end

  assign o_Tx_DV    = tx_dv_reg;
  assign o_Tx_Byte  = tx_byte_reg;
  assign o_Grant_Id = grant_reg;
  assign o_Busy     = busy_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Two arbiters: inst0 is built with GAP_CYCLES=2 and inst1 with GAP_CYCLES=0.
// A queue-based producer drives the requests of each arbiter, holding DV until
// the byte is taken. A transmitter stand-in pulses done 20 cycles after each
// launch. A behavioural model describes the scheduler as "outstanding byte
// plus gap clocks left", and the outputs of both arbiters are compared with it
// on every cycle. Directed tests also check hand-computed launch orders and
// timings.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int TX_LEN = 20;
  localparam int GAP0   = 2;
  localparam int GAP1   = 0;

  typedef struct {
    int inst;
    int id;
    int b;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst      [2];
  logic [N-1:0]    req_dv   [2];
  logic [N*DW-1:0] req_byte [2];
  logic            tx_done  [2];
  logic [N-1:0]    rdy      [2];
  logic            tx_dv    [2];
  logic [DW-1:0]   tx_byte  [2];
  logic [1:0]      grant    [2];
  logic            busy     [2];

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP0)) u_dut0 (
    .i_Clock(clk), .i_Reset(rst[0]), .i_Req_DV(req_dv[0]), .i_Req_Byte(req_byte[0]),
    .o_Req_Ready(rdy[0]), .o_Tx_DV(tx_dv[0]), .o_Tx_Byte(tx_byte[0]),
    .i_Tx_Done(tx_done[0]), .o_Grant_Id(grant[0]), .o_Busy(busy[0])
  );

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP1)) u_dut1 (
    .i_Clock(clk), .i_Reset(rst[1]), .i_Req_DV(req_dv[1]), .i_Req_Byte(req_byte[1]),
    .o_Req_Ready(rdy[1]), .o_Tx_DV(tx_dv[1]), .o_Tx_Byte(tx_byte[1]),
    .i_Tx_Done(tx_done[1]), .o_Grant_Id(grant[1]), .o_Busy(busy[1])
  );

  // Bookkeeping
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  ev_t  lg [$];          // launches seen on the DUT
  ev_t  dn [$];          // done pulses issued by the transmitter stand-in
  ev_t  fl [$];          // o_Busy falling transitions
  int   low0_cnt = 0;    // cycles with inst0 o_Req_Ready[0] low

  // Producers
  logic [7:0] pq [2*N][$];
  bit         acc_flag [2*N];
  int         acc_cyc  [2*N];

  // Transmitter stand-in
  int rem [2];
  bit force_done [2];

  // Behavioural model state
  bit         mvalid [2];
  bit         m_full [2*N];
  logic [7:0] m_hold [2*N];
  bit         m_out  [2];
  int         m_gap  [2];
  int         m_rr   [2];
  bit         m_dv   [2];
  logic [7:0] m_byte [2];
  int         m_id   [2];
  bit         m_busy [2];

  int exp_id [8];
  int exp_b  [8];

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP0 : GAP1;
  endfunction

  task automatic chk(input string name, input int inst, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s inst%0d cycle %0d: got 0x%0h, required 0x%0h", name, inst, cyc, act, exp);
    end
  endtask

  // One model step per rising edge, using the inputs present at that edge.
  task automatic model_step(input int i, input logic s_rst, input logic [N-1:0] s_dv,
                            input logic [N*DW-1:0] s_byte, input logic s_done);
    bit pre [N];
    bit found;
    int k;
    if (s_rst) begin
      mvalid[i] = 1'b1;
      for (int j = 0; j < N; j++) begin
        m_full[i*N+j] = 1'b0;
        m_hold[i*N+j] = 8'h00;
      end
      m_out[i]  = 1'b0;
      m_gap[i]  = 0;
      m_rr[i]   = N - 1;
      m_dv[i]   = 1'b0;
      m_byte[i] = 8'h00;
      m_id[i]   = 0;
      m_busy[i] = 1'b0;
    end else begin
      for (int j = 0; j < N; j++) pre[j] = m_full[i*N+j];
      m_dv[i] = 1'b0;
      if (!m_out[i] && m_gap[i] == 0) begin
        found = 1'b0;
        for (int j = 1; j <= N; j++) begin
          k = (m_rr[i] + j) % N;
          if (pre[k] && !found) begin
            found         = 1'b1;
            m_dv[i]       = 1'b1;
            m_byte[i]     = m_hold[i*N+k];
            m_id[i]       = k;
            m_rr[i]       = k;
            m_out[i]      = 1'b1;
            m_full[i*N+k] = 1'b0;
          end
        end
      end else if (m_out[i]) begin
        if (s_done) begin
          m_out[i] = 1'b0;
          m_gap[i] = gap_of(i);
        end
      end else begin
        m_gap[i] = m_gap[i] - 1;
      end
      m_busy[i] = m_out[i] || (m_gap[i] > 0);
      for (int j = 0; j < N; j++) begin
        if (s_dv[j] && !pre[j]) begin
          m_full[i*N+j] = 1'b1;
          m_hold[i*N+j] = s_byte[j*DW +: DW];
        end
      end
    end
  endtask

  // Model update at each rising edge; compare on the following falling edge.
  initial begin : model_and_compare
    logic [N-1:0] m_ready;
    bit           prev_busy [2];
    ev_t          e;
    prev_busy = '{1'b0, 1'b0};
    mvalid    = '{1'b0, 1'b0};
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) model_step(i, rst[i], req_dv[i], req_byte[i], tx_done[i]);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mvalid[i]) begin
          for (int j = 0; j < N; j++) m_ready[j] = !m_full[i*N+j];
          chk("ready",   i, rdy[i],     m_ready);
          chk("tx_dv",   i, tx_dv[i],   m_dv[i]);
          chk("tx_byte", i, tx_byte[i], m_byte[i]);
          chk("grant",   i, grant[i],   m_id[i]);
          chk("busy",    i, busy[i],    m_busy[i]);
          if (tx_dv[i] === 1'b1) begin
            e.inst = i; e.id = int'(grant[i]); e.b = int'(tx_byte[i]); e.cyc = cyc;
            lg.push_back(e);
            $display("[TB] inst%0d launch id=%0d byte=0x%02h cycle=%0d", i, grant[i], tx_byte[i], cyc);
          end
          if (prev_busy[i] && busy[i] === 1'b0) begin
            e.inst = i; e.id = 0; e.b = 0; e.cyc = cyc;
            fl.push_back(e);
          end
          prev_busy[i] = (busy[i] === 1'b1);
          if (i == 0 && rdy[0][0] === 1'b0) low0_cnt++;
        end
      end
    end
  end

  // Producers: present the head of each queue and hold DV until it is taken.
  initial begin : producers
    int q;
    for (int i = 0; i < 2; i++) begin
      req_dv[i]   = '0;
      req_byte[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < N; k++) begin
          q = i*N + k;
          if (acc_flag[q]) void'(pq[q].pop_front());
          acc_flag[q] = 1'b0;
          if (pq[q].size() > 0) begin
            req_dv[i][k]             = 1'b1;
            req_byte[i][k*DW +: DW]  = pq[q][0];
          end else begin
            req_dv[i][k] = 1'b0;
          end
          if (req_dv[i][k] && rdy[i][k] === 1'b1 && !rst[i]) begin
            acc_flag[q] = 1'b1;
            acc_cyc[q]  = cyc;
          end
        end
      end
    end
  end

  // Transmitter stand-in: a done pulse TX_LEN cycles after each launch.
  initial begin : transmitter
    bit  d;
    ev_t e;
    rem        = '{0, 0};
    force_done = '{1'b0, 1'b0};
    tx_done[0] = 1'b0;
    tx_done[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        d = 1'b0;
        if (rst[i]) rem[i] = 0;
        else if (tx_dv[i] === 1'b1) rem[i] = TX_LEN;
        else if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) d = 1'b1;
        end
        tx_done[i] = d || force_done[i];
        if (tx_done[i]) begin
          e.inst = i; e.id = 0; e.b = 0; e.cyc = cyc;
          dn.push_back(e);
        end
        force_done[i] = 1'b0;
      end
    end
  end

  function automatic int nth_cyc(input ev_t q[$], input int i, input int mark, input int nth);
    int c = 0;
    for (int j = mark; j < q.size(); j++) begin
      if (q[j].inst == i) begin
        if (c == nth) return q[j].cyc;
        c++;
      end
    end
    return -1000;
  endfunction

  task automatic push(input int i, input int k, input logic [7:0] b);
    pq[i*N+k].push_back(b);
  endtask

  task automatic do_reset(input int i);
    @(posedge clk); #1;
    rst[i] = 1'b1;
    @(posedge clk); #1;
    rst[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int  t;
    bit  empty;
    bit  ok;
    ok = 1'b0;
    for (t = 0; t < budget && !ok; t++) begin
      @(negedge clk); #1;
      empty = 1'b1;
      for (int k = 0; k < N; k++) if (pq[i*N+k].size() != 0) empty = 1'b0;
      ok = empty && rdy[i] == '1 && busy[i] === 1'b0 && tx_dv[i] === 1'b0 && rem[i] == 0;
    end
    chk("idle_within_budget", i, ok, 1);
  endtask

  task automatic expect_seq(input int i, input int mark, input int n);
    int c = 0;
    for (int j = mark; j < lg.size(); j++) begin
      if (lg[j].inst == i) begin
        if (c < 8) begin
          chk("launch_id",   i, lg[j].id, exp_id[c]);
          chk("launch_byte", i, lg[j].b,  exp_b[c]);
        end
        c++;
      end
    end
    chk("launch_count", i, c, n);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int mark, dmark, fmark, lc, dc, fc;
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Reset state
    chk("rst_ready", 0, rdy[0], 4'hF);
    chk("rst_tx_dv", 0, tx_dv[0], 0);
    chk("rst_byte",  0, tx_byte[0], 0);
    chk("rst_grant", 0, grant[0], 0);
    chk("rst_busy",  0, busy[0], 0);
    chk("rst_ready", 1, rdy[1], 4'hF);

    // T1: single request from req0
    mark = lg.size(); dmark = dn.size(); fmark = fl.size(); low0_cnt = 0;
    push(0, 0, 8'h54);
    wait_idle(0, 200);
    exp_id = '{0,0,0,0,0,0,0,0}; exp_b = '{'h54,0,0,0,0,0,0,0};
    expect_seq(0, mark, 1);
    lc = nth_cyc(lg, 0, mark, 0);
    chk("accept_to_launch", 0, lc - acc_cyc[0], 2);
    chk("ready0_low_cycles", 0, low0_cnt, 1);
    dc = nth_cyc(dn, 0, dmark, 0);
    chk("done_after_launch", 0, dc - lc, TX_LEN);
    fc = nth_cyc(fl, 0, fmark, 0);
    chk("busy_cycles_after_done", 0, fc - dc - 1, 2);

    // T2: four simultaneous requests
    do_reset(0);
    mark = lg.size(); dmark = dn.size();
    push(0, 0, 8'hA0); push(0, 1, 8'hA1); push(0, 2, 8'hA2); push(0, 3, 8'hA3);
    wait_idle(0, 400);
    exp_id = '{0,1,2,3,0,0,0,0}; exp_b = '{'hA0,'hA1,'hA2,'hA3,0,0,0,0};
    expect_seq(0, mark, 4);
    for (int k = 1; k < 4; k++)
      chk("launch_ge3_after_done", 0,
          (nth_cyc(lg, 0, mark, k) - nth_cyc(dn, 0, dmark, k-1)) >= 3, 1);

    // T3: fairness, req1 refilling while req3 waits
    do_reset(0);
    mark = lg.size();
    push(0, 1, 8'hB1); push(0, 1, 8'hB1);
    push(0, 3, 8'hC3); push(0, 3, 8'hC3);
    wait_idle(0, 600);
    exp_id = '{1,3,1,3,0,0,0,0}; exp_b = '{'hB1,'hC3,'hB1,'hC3,0,0,0,0};
    expect_seq(0, mark, 4);

    // T4: back-pressure on req2
    mark = lg.size();
    push(0, 2, 8'h11);
    @(posedge clk); #1;
    push(0, 2, 8'h22);
    wait_idle(0, 400);
    exp_id = '{2,2,0,0,0,0,0,0}; exp_b = '{'h11,'h22,0,0,0,0,0,0};
    expect_seq(0, mark, 2);

    // T5: reset while waiting for done with req0/req1 full
    do_reset(0);
    mark = lg.size();
    push(0, 0, 8'h50); push(0, 0, 8'h51); push(0, 1, 8'h61);
    for (int t = 0; t < 20 && nth_cyc(lg, 0, mark, 0) < 0; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    #1;
    chk("wait_done_regs_full", 0, rdy[0][1:0], 0);
    do_reset(0);
    chk("rst_mid_ready", 0, rdy[0], 4'hF);
    chk("rst_mid_tx_dv", 0, tx_dv[0], 0);
    chk("rst_mid_busy",  0, busy[0], 0);
    mark = lg.size();
    force_done[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("late_done_no_launch", 0, nth_cyc(lg, 0, mark, 0) < 0, 1);
    push(0, 3, 8'h7E);
    wait_idle(0, 200);
    exp_id = '{3,0,0,0,0,0,0,0}; exp_b = '{'h7E,0,0,0,0,0,0,0};
    expect_seq(0, mark, 1);

    // T6: zero-gap build, second byte queued behind the first
    do_reset(1);
    mark = lg.size(); dmark = dn.size(); fmark = fl.size();
    push(1, 0, 8'h01); push(1, 1, 8'h02);
    wait_idle(1, 300);
    exp_id = '{0,1,0,0,0,0,0,0}; exp_b = '{'h01,'h02,0,0,0,0,0,0};
    expect_seq(1, mark, 2);
    dc = nth_cyc(dn, 1, dmark, 0);
    fc = nth_cyc(fl, 1, fmark, 0);
    lc = nth_cyc(lg, 1, mark, 1);
    chk("gap0_busy_fall", 1, fc - dc, 1);
    chk("gap0_busy_low_one_cycle", 1, lc - fc, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
